// File: rtl/swd_ise_pkg.sv
// ============================================================================
// Module      : swd_ise_pkg
// Description : Shared state, opcode and status-bit definitions for swd ISE units
// Revision    : 1.0
// ============================================================================
`default_nettype none

package swd_ise_pkg;

   localparam logic [3:0] ST_LOAD_X01 = 4'd0;
   localparam logic [3:0] ST_LOAD_X23 = 4'd1;
   localparam logic [3:0] ST_LOAD_Y01 = 4'd2;
   localparam logic [3:0] ST_LOAD_Y23 = 4'd3;
   localparam logic [3:0] ST_EXEC     = 4'd4;
   localparam logic [3:0] ST_DRAIN    = 4'd5;
   localparam logic [3:0] ST_UNLOAD_2 = 4'd6;
   localparam logic [3:0] ST_UNLOAD_1 = 4'd7;
   localparam logic [3:0] ST_UNLOAD_0 = 4'd8;

   typedef enum logic [3:0] {
      LOAD_X01 = ST_LOAD_X01,
      LOAD_X23 = ST_LOAD_X23,
      LOAD_Y01 = ST_LOAD_Y01,
      LOAD_Y23 = ST_LOAD_Y23,
      EXEC     = ST_EXEC,
      DRAIN    = ST_DRAIN,
      UNLOAD_2 = ST_UNLOAD_2,
      UNLOAD_1 = ST_UNLOAD_1,
      UNLOAD_0 = ST_UNLOAD_0
   } ise_state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_XOR = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   localparam int SR_C = 0;
   localparam int SR_Z = 1;

endpackage

`default_nettype wire

// File: rtl/swd_alu32_core.sv
// ============================================================================
// Module      : swd_alu32_core
// Description : Combinational 32-bit ADD/XOR/SUB/AND with carry and zero flags
// Revision    : 1.0
// ============================================================================
`default_nettype none

module swd_alu32_core
   import swd_ise_pkg::*;
(
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [1:0]  op,
   output logic [31:0] r,
   output logic        c,
   output logic        z
);

   logic [32:0] w_sum;

   // SUB reuses the adder as X + ~Y + 1 so carry-out means "no borrow"
   always_comb begin
      w_sum = '0;
      r     = '0;
      c     = 1'b0;
      case (op)
         OP_ADD: begin
            w_sum = {1'b0, x} + {1'b0, y};
            r     = w_sum[31:0];
            c     = w_sum[32];
         end
         OP_SUB: begin
            w_sum = {1'b0, x} + {1'b0, ~y} + 33'd1;
            r     = w_sum[31:0];
            c     = w_sum[32];
         end
         OP_XOR:  r = x ^ y;
         default: r = x & y;
      endcase
   end

   assign z = (r == 32'd0);

endmodule

`default_nettype wire

// File: rtl/swd_alu32_ise.sv
// ============================================================================
// Module      : swd_alu32_ise
// Description : Byte-serial 32-bit ALU instruction-set extension (load/exec/unload)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module swd_alu32_ise
   import swd_ise_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] sr,
   output logic [7:0] sr_out,
   output logic [7:0] result,
   output logic       wait_req
);

   ise_state_t  r_state;
   ise_state_t  w_state_next;
   logic [31:0] r_x;
   logic [31:0] r_y;
   logic [31:0] r_r;
   logic [1:0]  r_op;
   logic        r_c;
   logic        r_z;
   logic        r_flags_valid;
   logic [7:0]  r_result;
   logic [31:0] w_r;
   logic        w_c;
   logic        w_z;

   swd_alu32_core u_core (
      .x  (r_x),
      .y  (r_y),
      .op (r_op),
      .r  (w_r),
      .c  (w_c),
      .z  (w_z)
   );

   always_ff @(posedge clk) begin
      if (!rst) r_state <= LOAD_X01;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         LOAD_X01: if (start) w_state_next = LOAD_X23;
         LOAD_X23: if (start) w_state_next = LOAD_Y01;
         LOAD_Y01: if (start) w_state_next = LOAD_Y23;
         LOAD_Y23: if (start) w_state_next = EXEC;
         EXEC:     if (start) w_state_next = DRAIN;
         DRAIN:               w_state_next = UNLOAD_2;
         UNLOAD_2: if (start) w_state_next = UNLOAD_1;
         UNLOAD_1: if (start) w_state_next = UNLOAD_0;
         UNLOAD_0: if (start) w_state_next = LOAD_X01;
         default:             w_state_next = LOAD_X01;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_x           <= '0;
         r_y           <= '0;
         r_r           <= '0;
         r_op          <= '0;
         r_c           <= 1'b0;
         r_z           <= 1'b0;
         r_flags_valid <= 1'b0;
         r_result      <= 8'h00;
      end else begin
         case (r_state)
            LOAD_X01: if (start) begin
               r_x[15:0]     <= {b, a};
               r_flags_valid <= 1'b0;
            end
            LOAD_X23: if (start) r_x[31:16] <= {b, a};
            LOAD_Y01: if (start) r_y[15:0]  <= {b, a};
            LOAD_Y23: if (start) r_y[31:16] <= {b, a};
            EXEC:     if (start) r_op       <= a[1:0];
            DRAIN: begin
               r_r           <= w_r;
               r_c           <= w_c;
               r_z           <= w_z;
               r_flags_valid <= 1'b1;
               r_result      <= w_r[31:24];
            end
            UNLOAD_2: if (start) r_result <= r_r[23:16];
            UNLOAD_1: if (start) r_result <= r_r[15:8];
            UNLOAD_0: if (start) r_result <= r_r[7:0];
            default: ;
         endcase
      end
   end

   assign result = r_result;

   // Stall covers the EXEC strobe cycle (combinational) and the DRAIN cycle
   assign wait_req = ((r_state == EXEC) && start && rst) || (r_state == DRAIN);

   always_comb begin
      sr_out = sr;
      if (r_flags_valid) begin
         sr_out[SR_C] = r_c;
         sr_out[SR_Z] = r_z;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_swd_alu32_ise.sv
// ============================================================================
// Module      : tb_swd_alu32_ise
// Description : Scoreboard bench for swd_alu32_ise byte-serial ALU
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_swd_alu32_ise;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] sr;
   logic [7:0] sr_out;
   logic [7:0] result;
   logic       wait_req;

   int n_checks;
   int n_pass;
   int wait_cnt;

   logic [7:0] q_bytes[$];
   logic [1:0] q_flags[$];

   swd_alu32_ise dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .sr       (sr),
      .sr_out   (sr_out),
      .result   (result),
      .wait_req (wait_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (wait_req) wait_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Reference ALU: returns {z, c, r}
   function automatic logic [33:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                           input logic [1:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic        c;
      s = '0;
      c = 1'b0;
      case (op)
         2'b00: begin s = {1'b0, x} + {1'b0, y}; r = s[31:0]; c = s[32]; end
         2'b01: r = x ^ y;
         2'b10: begin s = {1'b0, x} - {1'b0, y}; r = s[31:0]; c = (x >= y); end
         default: r = x & y;
      endcase
      return {(r == 32'd0), c, r};
   endfunction

   task automatic pulse(input logic [7:0] pa, input logic [7:0] pb);
      a     = pa;
      b     = pb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic gap_idle(input int n, input string tag);
      logic [7:0] held;
      held = result;
      repeat (n) begin
         @(posedge clk);
         #1;
         check(tag, {24'd0, result}, {24'd0, held});
      end
   endtask

   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op,
                         input int gap, input logic poke_drain);
      logic [33:0] m;
      logic [1:0]  fl;
      int          w0;
      m = ref_alu(x, y, op);
      for (int i = 3; i >= 0; i--) q_bytes.push_back(m[i*8 +: 8]);
      q_flags.push_back(m[33:32]);

      pulse(x[7:0], x[15:8]);
      check("flags_cleared", {24'd0, sr_out}, {24'd0, sr});
      gap_idle(gap, "gap_x01");
      pulse(x[23:16], x[31:24]);
      gap_idle(gap, "gap_x23");
      pulse(y[7:0], y[15:8]);
      gap_idle(gap, "gap_y01");
      pulse(y[23:16], y[31:24]);
      gap_idle(gap, "gap_y23");

      w0    = wait_cnt;
      a     = {6'b101010, op};
      b     = 8'hC3;
      start = 1'b1;
      #1;
      check("wait_exec", {31'd0, wait_req}, 32'd1);
      @(posedge clk);
      #1;
      start = poke_drain;
      check("wait_drain", {31'd0, wait_req}, 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("wait_after", {31'd0, wait_req}, 32'd0);
      check("wait_cycles", wait_cnt - w0, 32'd2);
      fl = q_flags.pop_front();
      check("sr_flags", {24'd0, sr_out}, {24'd0, sr[7:2], fl});
      check("byte3", {24'd0, result}, {24'd0, q_bytes.pop_front()});
      gap_idle(gap, "gap_u2");
      pulse(8'h11, 8'h22);
      check("byte2", {24'd0, result}, {24'd0, q_bytes.pop_front()});
      gap_idle(gap, "gap_u1");
      pulse(8'h33, 8'h44);
      check("byte1", {24'd0, result}, {24'd0, q_bytes.pop_front()});
      gap_idle(gap, "gap_u0");
      pulse(8'h55, 8'h66);
      check("byte0", {24'd0, result}, {24'd0, q_bytes.pop_front()});
      check("flags_held", {24'd0, sr_out}, {24'd0, sr[7:2], fl});
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      wait_cnt = 0;
      rst      = 1'b0;
      start    = 1'b0;
      a        = 8'h00;
      b        = 8'h00;
      sr       = 8'hA5;
      repeat (2) @(posedge clk);
      #1;
      check("rst_result", {24'd0, result}, 32'd0);
      check("rst_wait", {31'd0, wait_req}, 32'd0);
      check("rst_sr", {24'd0, sr_out}, {24'd0, sr});
      rst = 1'b1;

      run_op(32'hFFFFFFFF, 32'h00000001, 2'b00, 0, 1'b0);
      run_op(32'h12345678, 32'hFF00FF00, 2'b01, 0, 1'b0);
      sr = 8'h5A;
      run_op(32'h00000000, 32'h00000001, 2'b10, 0, 1'b0);
      run_op(32'h5A5A5A5A, 32'h5A5A5A5A, 2'b10, 0, 1'b0);
      sr = 8'hA5;
      run_op(32'hF0F0F0F0, 32'h0FF00FF0, 2'b11, 3, 1'b1);

      // Mid-op reset with start asserted: reset must win
      pulse(8'hDE, 8'hAD);
      pulse(8'hBE, 8'hEF);
      pulse(8'h12, 8'h34);
      rst   = 1'b0;
      start = 1'b1;
      a     = 8'h77;
      @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b0;
      check("midrst_result", {24'd0, result}, 32'd0);
      check("midrst_wait", {31'd0, wait_req}, 32'd0);
      check("midrst_sr", {24'd0, sr_out}, {24'd0, sr});
      run_op(32'h00000002, 32'h00000003, 2'b00, 0, 1'b0);

      // Next op's first load must drop the flags from sr_out
      pulse(8'h01, 8'h02);
      check("flag_drop", {24'd0, sr_out}, 32'h000000A5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/swd_alu32_ise.md
# swd_alu32_ise

Byte-serial 32-bit arithmetic/logic instruction-set extension for the 8-bit core. It is the ARX stage that sits directly upstream of the 32-bit rotate unit. Software loads two 32-bit operands X and Y two bytes per instruction, issues an execute with an opcode, then unloads the 32-bit result one byte per instruction. Carry and zero flags are reported through the status-register path. It uses the same `start`/`a`/`b`/`sr`/`result`/`wait_req` ISE slot protocol as the other `swd_*_ise` units.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  one clock; reset is synchronous and active-low
- `start`  in  1  one-cycle instruction strobe from core; advances the FSM
- `a`  in  8  operand byte (low byte of pair / opcode in EXEC)
- `b`  in  8  operand byte (high byte of pair)
- `sr`  in  8  core status register
- `sr_out`  out  8  status register returned to core
- `result`  out  8  registered result byte
- `wait_req`  out  1  stall request to core

## Operation
- States, in order: LOAD_X01, LOAD_X23, LOAD_Y01, LOAD_Y23, EXEC, DRAIN, UNLOAD_2, UNLOAD_1, UNLOAD_0. After UNLOAD_0 the FSM returns to LOAD_X01.
- All states except DRAIN advance only on `start`=1 and hold otherwise. DRAIN always advances to UNLOAD_2 after one cycle.
- Operand loading on `start`:
  - LOAD_X01: X[7:0]<=a, X[15:8]<=b
  - LOAD_X23: X[23:16]<=a, X[31:24]<=b
  - LOAD_Y01: Y[7:0]<=a, Y[15:8]<=b
  - LOAD_Y23: Y[23:16]<=a, Y[31:24]<=b
- EXEC on `start`: op<=a[1:0]; `b` is ignored. Opcodes:
  - 00 = ADD: R = X+Y mod 2^32, C = carry out of bit 31
  - 01 = XOR: C = 0
  - 10 = SUB: R = X−Y mod 2^32, computed as X+~Y+1; C = carry out (1 = no borrow)
  - 11 = AND: C = 0
- Z = (R == 0) for all opcodes. Arithmetic is 33 bits wide internally; R is the low 32 bits.
- R, C and Z are registered at the edge leaving DRAIN. `result`<=R[31:24] at that same edge.
- Unload on `start`:
  - UNLOAD_2: `result`<=R[23:16]
  - UNLOAD_1: `result`<=R[15:8]
  - UNLOAD_0: `result`<=R[7:0]
- `result` holds its value in all other states and cycles.
- `sr_out`:
  - While `flags_valid`=1: `sr_out` = {sr[7:2], Z, C}.
  - Otherwise `sr_out` = `sr`.
  - `flags_valid` is set at DRAIN exit and cleared when `start` is accepted in LOAD_X01.
- `start` during DRAIN is ignored; the core is stalled, so this must not occur.
- X and Y are not cleared between operations. Reloading all four pairs is mandatory for each op.

## Timing
- Reset (`rst`=0 at an edge), including mid-operation:
  - state<=LOAD_X01; X, Y, R, op <= 0; C, Z, `flags_valid` <= 0
  - `result`<=8'h00; `wait_req` registered part <= 0
- Reset takes priority over `start` in the same cycle.
- `wait_req`:
  - Combinationally 1 in the EXEC cycle where `start`=1.
  - Registered 1 for the whole DRAIN cycle.
  - 0 in every other cycle, including the reset cycle's outputs.
- Latency: EXEC `start` at edge n (DRAIN entered). R[31:24] is in `result` and flags are in `sr_out` after edge n+1. The core sees 2 stall cycles.
- Each unload byte is valid on `result` from the edge that accepted the preceding `start`.
- Full sequence is 8 accepted `start` strobes plus 1 DRAIN cycle. There is no back-pressure beyond `wait_req`.

## Structure
- Shared package `swd_ise_pkg`:
  - state encoding localparams (4-bit)
  - opcode constants OP_ADD/OP_XOR/OP_SUB/OP_AND
  - status-register bit positions SR_C=0, SR_Z=1
- Natural sub-module: `swd_alu32_core`, purely combinational, (X, Y, op) -> (R, C, Z). The FSM, operand registers and byte mux stay in `swd_alu32_ise`.

## Test plan
- ADD wrap: X=FFFFFFFF, Y=00000001, op 00 -> bytes 00,00,00,00; `sr_out`[1:0]=2'b11; `wait_req` high exactly 2 cycles.
- XOR: X=12345678, Y=FF00FF00, op 01 -> bytes ED,34,A9,78; C=0, Z=0.
- SUB borrow: X=00000000, Y=00000001, op 10 -> bytes FF,FF,FF,FF; C=0, Z=0. Then X=Y=5A5A5A5A -> all 00; C=1, Z=1.
- AND with idle gaps: X=F0F0F0F0, Y=0FF00FF0, op 11, with 3 idle cycles between every `start` -> bytes 00,F0,00,F0. `result` is stable during gaps; `start` pulsed during DRAIN has no effect.
- Reset mid-op: after LOAD_Y01, drive `rst`=0 for one cycle -> LOAD_X01, `result`=00, `wait_req`=0, `sr_out`==`sr`. A full ADD 00000002+00000003 afterwards -> 00,00,00,05.
- Flag lifetime: after an ADD, `sr_out`[1:0] tracks Z/C until the next LOAD_X01 `start`, then `sr_out` equals `sr` with `sr`=A5.
